// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: FSM state encoding and
// the counter saturation helper.
package period_meter_pkg;

    typedef enum logic [1:0] {
        PM_IDLE      = 2'd0,
        PM_MEASURE   = 2'd1,
        PM_SATURATED = 2'd2
    } pm_state_e;

    localparam int PM_MIN_SYNC_STAGES = 2;

    // All-ones value of a counter that is `width` bits wide.
    function automatic logic [63:0] pm_sat_value(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/period_meter_sync.sv
// Multi-flop synchronizer for the measured input plus one history flop; emits
// the synchronized level and a single-cycle rising-edge pulse.
module period_meter_sync
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic s_o,
    output logic rise_o
);

    // A single-flop chain is not a synchronizer, so shallower settings are raised.
    localparam int STAGES = (SYNC_STAGES < PM_MIN_SYNC_STAGES) ? PM_MIN_SYNC_STAGES
                                                               : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;

    assign sync_d = {sync_q[STAGES-2:0], d_i};

    // NOTE: non-blocking assignments let every stage sample the pre-edge value
    // of its neighbour; blocking ones would collapse the chain into one flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign s_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures CLK cycles between rising edges of an asynchronous input and strobes
// each result. Optional high-time output H when PERIOD_METER_HIGHTIME_EN is defined.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 22,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I,
    output logic [WIDTH-1:0] O,
    output logic             VALID,
    output logic             OVF
`ifdef PERIOD_METER_HIGHTIME_EN
    ,
    output logic [WIDTH-1:0] H
`endif
);

    localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(pm_sat_value(WIDTH));
    localparam logic [WIDTH-1:0] CNT_MAX_M1 = CNT_MAX - WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    logic s;
    logic rise;

    period_meter_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (CLK),
        .rst_ni(RESETN),
        .d_i   (I),
        .s_o   (s),
        .rise_o(rise)
    );

    pm_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    // NOTE: each always_comb assigns its outputs a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= PM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave MEASURE one cycle early so a rise landing on an all-ones count is flagged.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PM_IDLE: begin
                if (rise) state_d = PM_MEASURE;
            end
            PM_MEASURE: begin
                if (!rise && cnt_q >= CNT_MAX_M1) state_d = PM_SATURATED;
            end
            PM_SATURATED: begin
                if (rise) state_d = PM_MEASURE;
            end
            default: state_d = PM_IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        o_d     = o_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            PM_MEASURE: begin
                if (rise) begin
                    valid_d = 1'b1;
                    o_d     = cnt_q;
                    ovf_d   = 1'b0;
                end
            end
            PM_SATURATED: begin
                if (rise) begin
                    valid_d = 1'b1;
                    o_d     = CNT_MAX;
                    ovf_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q   <= '0;
            o_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign O     = o_q;
    assign OVF   = ovf_q;
    assign VALID = valid_q;

`ifdef PERIOD_METER_HIGHTIME_EN
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] h_q, h_d;

    // The rise cycle itself has s high, hence the restart at one.
    always_comb begin
        hcnt_d = hcnt_q;
        if (rise) begin
            hcnt_d = CNT_ONE;
        end else if (s && hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + CNT_ONE;
        end
    end

    always_comb begin
        h_d = h_q;
        if (valid_d) h_d = hcnt_q;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hcnt_q <= '0;
            h_q    <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            h_q    <= h_d;
        end
    end

    assign H = h_q;
`else
    logic sync_level_unused;
    assign sync_level_unused = s;
`endif

endmodule
